// File: rtl/pill_io_pkg.sv
// pill_io_pkg: shared types and constants for the pill dispenser input path.
//   debounce_state_e      per-channel debounce FSM state encoding
//   CLK_HZ                system clock frequency
//   *_DEF                 default debounce / auto-repeat cycle counts at CLK_HZ
package pill_io_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } debounce_state_e;

   localparam int CLK_HZ             = 50_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;   // 10 ms
   localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;     // 500 ms
   localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 5;     // 200 ms

endpackage

// File: rtl/pill_input_conditioner_debounce_channel.sv
// debounce_channel: one input bit -> 2-flop synchroniser, debounce FSM with
// qualification counter, registered rise pulse and optional key auto-repeat.
//   clk, rst_n   system clock, async active-low reset
//   raw          asynchronous pin (polarity set by INVERT)
//   level        debounced level, 1 = active
//   press        one-cycle pulse on debounced 0->1 (only when PULSE_EN)
// Optional macro PILL_KEY_REPEAT_EN: adds a hold counter producing repeat
// pulses while the level stays high.
//
// state   | meaning
// IDLE_LO | level 0, input agrees
// WAIT_HI | level 0, input high, counting stable cycles
// IDLE_HI | level 1, input agrees
// WAIT_LO | level 1, input low, counting stable cycles
module debounce_channel
   import pill_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   parameter bit INVERT          = 1'b0,
   parameter bit PULSE_EN        = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1, sync2, active;
   debounce_state_e state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic            level_nx, rise, press_nx;

   // Synchroniser resets to the pin's inactive level so nothing qualifies
   // spuriously out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= INVERT;
         sync2 <= INVERT;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   assign active = sync2 ^ INVERT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE_LO;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         level <= level_nx;
         press <= press_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level;
      rise     = 1'b0;
      case (state)
         IDLE_LO: if (active) begin
            state_nx = WAIT_HI;
            cnt_nx   = CNT_W'(1);
         end
         WAIT_HI: begin
            if (!active) begin
               state_nx = IDLE_LO;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE_HI;
               level_nx = 1'b1;
               cnt_nx   = '0;
               rise     = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         IDLE_HI: if (!active) begin
            state_nx = WAIT_LO;
            cnt_nx   = CNT_W'(1);
         end
         WAIT_LO: begin
            if (active) begin
               state_nx = IDLE_HI;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE_LO;
               level_nx = 1'b0;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE_LO;
            cnt_nx   = '0;
         end
      endcase
   end

`ifdef PILL_KEY_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [HOLD_W-1:0] hold_cnt, hold_last;
   logic              hold_first, fall, repeat_fire;

   // The level drops on the same edge as a would-be repeat: suppress it.
   assign fall        = (state == WAIT_LO) && !active && (cnt == CNT_LAST);
   assign hold_last   = hold_first ? HOLD_W'(REPEAT_DELAY - 1) : HOLD_W'(REPEAT_PERIOD - 1);
   assign repeat_fire = PULSE_EN && level && !fall && (hold_cnt == hold_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt   <= '0;
         hold_first <= 1'b1;
      end else if (!level || fall) begin
         hold_cnt   <= '0;
         hold_first <= 1'b1;
      end else if (repeat_fire) begin
         hold_cnt   <= '0;
         hold_first <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign press_nx = (PULSE_EN && rise) || repeat_fire;
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

   assign press_nx = PULSE_EN && rise;
`endif

endmodule

// File: rtl/pill_input_conditioner.sv
// pill_input_conditioner: synchronises and debounces every board input of
// the pill dispenser before it reaches the control FSM.
//   clk, rst_n    system clock (50 MHz), async active-low reset
//   keysIn        raw push-buttons, 0 = pressed
//   switchesIn    raw slide switches, 1 = on
//   keysLevel     debounced keys, 1 = pressed
//   keysPress     one-cycle pulse per debounced press
//   switchesOut   debounced switches
//   anyKeyPress   OR of keysPress
// Optional macro PILL_KEY_REPEAT_EN enables key auto-repeat pulses.
module pill_input_conditioner
   import pill_io_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int NUM_SW          = 18,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] keysIn,
   input  logic [NUM_SW-1:0]   switchesIn,
   output logic [NUM_KEYS-1:0] keysLevel,
   output logic [NUM_KEYS-1:0] keysPress,
   output logic [NUM_SW-1:0]   switchesOut,
   output logic                anyKeyPress
);

   // Switch channels are built without pulse logic; their press is tied low.
   logic [NUM_SW-1:0] unused_sw_press;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .INVERT         (1'b1),
         .PULSE_EN       (1'b1)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (keysIn[i]),
         .level(keysLevel[i]),
         .press(keysPress[i])
      );
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .INVERT         (1'b0),
         .PULSE_EN       (1'b0)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (switchesIn[i]),
         .level(switchesOut[i]),
         .press(unused_sw_press[i])
      );
   end

   assign anyKeyPress = |keysPress;

endmodule
